timed_ram256: RTL

TIMED_RAM256 -- requirements
Module: timed_ram256

---
 rtl/timed_ram256.sv | 134 +++++++++++++
 1 files changed

// File: rtl/timed_ram256.sv
// +--------------------------------------------------------------------------+
// | timed_ram256 : 256x8 big-endian RAM behind a four-phase MOV/MOC handshake |
// | Option: TIMED_RAM_WAIT_STATE_EN enables WAIT_CYCLES wait states.  Rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module timed_ram256 #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MOV,
  input  logic        ReadWrite,
  input  logic [7:0]  Address,
  input  logic [31:0] DataIn,
  input  logic [1:0]  Mode,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        Busy
);

`ifdef TIMED_RAM_WAIT_STATE_EN
  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);
`else
  // WAIT_CYCLES has no effect in this build; the expression only keeps it referenced
  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES - WAIT_CYCLES + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  mode_q;
  logic        rd_q;

  logic [7:0]  Memory [0:255];

  logic [7:0]  w_ea;
  logic [31:0] w_rdata;

  always_comb begin
    w_ea = addr_q;
    case (mode_q)
      2'b00:   w_ea = addr_q;
      2'b01:   w_ea = {addr_q[7:1], 1'b0};
      default: w_ea = {addr_q[7:2], 2'b00};
    endcase
  end

  always_comb begin
    w_rdata = 32'd0;
    case (mode_q)
      2'b00:   w_rdata = {24'd0, Memory[w_ea]};
      2'b01:   w_rdata = {16'd0, Memory[w_ea], Memory[w_ea | 8'd1]};
      default: w_rdata = {Memory[w_ea], Memory[w_ea | 8'd1],
                          Memory[w_ea | 8'd2], Memory[w_ea | 8'd3]};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 8'd0;
      wdata_q <= 32'd0;
      mode_q  <= 2'b00;
      rd_q    <= 1'b0;
      DataOut <= 32'd0;
      MOC     <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (MOV) begin
            addr_q  <= Address;
            wdata_q <= DataIn;
            mode_q  <= Mode;
            rd_q    <= ReadWrite;
            cnt_q   <= c_wait_load;
            Busy    <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (rd_q) begin
              DataOut <= w_rdata;
            end else begin
              // Most significant byte of the transfer lands at the lowest address
              case (mode_q)
                2'b00: Memory[w_ea] <= wdata_q[7:0];
                2'b01: begin
                  Memory[w_ea]        <= wdata_q[15:8];
                  Memory[w_ea | 8'd1] <= wdata_q[7:0];
                end
                default: begin
                  Memory[w_ea]        <= wdata_q[31:24];
                  Memory[w_ea | 8'd1] <= wdata_q[23:16];
                  Memory[w_ea | 8'd2] <= wdata_q[15:8];
                  Memory[w_ea | 8'd3] <= wdata_q[7:0];
                end
              endcase
            end
            MOC     <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!MOV) begin
            MOC     <= 1'b0;
            Busy    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          MOC     <= 1'b0;
          Busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
